data_sram_arbiter: RTL

- Shares the single-port data SRAM between two requesters.
- Requester 0 is the pipeline load/store path from execute, with response consumed in memory stage.
- Requester 1 is a secondary master (debug/DMA).
- Sequences each access into an SRAM enable cycle, tracks the one in-flight response, and routes read data and completion back to the owner. Arbitration is round-robin or fixed-priority with an anti-starvation counter.

---
 rtl/data_sram_arbiter_if.sv | 45 ++++
 rtl/data_sram_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/data_sram_arbiter_if.sv
// Bundle of the two requester ports and the single-port data SRAM port.
// The slave modport is the arbiter's view. The master modport is the environment's view: requesters and SRAM.
interface data_sram_arbiter_if;
  logic        req0;
  logic        wr0;
  logic [3:0]  wstrb0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        addr_ok0;
  logic        data_ok0;
  logic [31:0] rdata0;

  logic        req1;
  logic        wr1;
  logic [3:0]  wstrb1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        addr_ok1;
  logic        data_ok1;
  logic [31:0] rdata1;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport slave (
    input  req0, wr0, wstrb0, addr0, wdata0,
    output addr_ok0, data_ok0, rdata0,
    input  req1, wr1, wstrb1, addr1, wdata1,
    output addr_ok1, data_ok1, rdata1,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport master (
    output req0, wr0, wstrb0, addr0, wdata0,
    input  addr_ok0, data_ok0, rdata0,
    output req1, wr1, wstrb1, addr1, wdata1,
    input  addr_ok1, data_ok1, rdata1,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_arbiter.sv
// Two-requester arbiter for the single-port data SRAM with a fixed one-cycle response.
// Arbitration is either round-robin or fixed-priority; fixed-priority mode has a starvation limit for requester 1.
module data_sram_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned MAX_WAIT   = 8
) (
  input logic              clk,
  input logic              reset,
  data_sram_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic       rr_last_q, rr_last_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_id_q, resp_id_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic gnt_vld;
  logic gnt_id;

  // Grant is purely combinational, so a request is accepted in the same cycle it is granted.
  // Holding reset low blocks every grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (reset) begin
      if (bus.req0 && bus.req1) begin
        gnt_vld = 1'b1;
        if (FIXED_PRIO != 0) gnt_id = (wait_cnt_q == MAX_W);
        else                 gnt_id = ~rr_last_q;
      end else if (bus.req0) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (bus.req1) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  always_comb begin
    bus.addr_ok0        = gnt_vld & ~gnt_id;
    bus.addr_ok1        = gnt_vld &  gnt_id;
    bus.data_sram_en    = gnt_vld;
    bus.data_sram_wen   = '0;
    bus.data_sram_addr  = bus.addr0;
    bus.data_sram_wdata = bus.wdata0;
    if (gnt_id) begin
      bus.data_sram_addr  = bus.addr1;
      bus.data_sram_wdata = bus.wdata1;
      if (gnt_vld && bus.wr1) bus.data_sram_wen = bus.wstrb1;
    end else begin
      if (gnt_vld && bus.wr0) bus.data_sram_wen = bus.wstrb0;
    end
  end

  // SRAM read data is returned straight to the owner of the in-flight access.
  always_comb begin
    bus.data_ok0 = resp_valid_q & ~resp_id_q;
    bus.data_ok1 = resp_valid_q &  resp_id_q;
    bus.rdata0   = bus.data_ok0 ? bus.data_sram_rdata : '0;
    bus.rdata1   = bus.data_ok1 ? bus.data_sram_rdata : '0;
  end

  always_comb begin
    rr_last_d    = gnt_vld ? gnt_id : rr_last_q;
    resp_valid_d = gnt_vld;
    resp_id_d    = gnt_vld ? gnt_id : resp_id_q;
    wait_cnt_d   = wait_cnt_q;
    if (FIXED_PRIO == 0 || !bus.req1 || bus.addr_ok1) wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_W)                     wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q    <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule
